pio_in_capture: RTL and testbench



---
 rtl/pio_pkg.sv | 21 ++
 rtl/pio_debounce.sv | 77 +++++++
 rtl/pio_in_capture.sv | 112 +++++++++++
 tb/tb_pio_in_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register map, edge capture modes
// and a helper that sizes the debounce counters.
package pio_pkg;

    // Register addresses on the 2-bit Avalon address bus
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge capture modes selected by the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter width able to hold DEBOUNCE_CYCLES-1 with one bit of headroom
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit synchroniser followed by an optional consecutive-sample
// debouncer. With DEBOUNCE_CYCLES=0 the synchroniser output goes straight out.
module pio_debounce
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_out;

    // Shift the raw input one stage deeper into the synchroniser each clock
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchroniser flops, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign dout = s_out;
        end else begin : g_debounce
            localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // Accept a new level only after enough consecutive differing samples;
            // any sample that matches the current level restarts the count
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (s_out == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = s_out;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Debounce state; reset discards any partially accumulated count
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign dout = stable_q;
        end
    endgenerate

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO: synchronised/debounced inputs, sticky edge capture
// with write-1-to-clear, masked level interrupt and a registered read port.
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] readdata_q;
    logic [WIDTH-1:0] readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             wr_en;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[i]),
                .dout    (stable[i])
            );
        end
    endgenerate

    assign wr_en = chipselect && !write_n;

    // Compare the stable level with last clock's copy to find selected edges
    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_det = stable & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_det = ~stable & prev_q;
        end else begin
            edge_det = stable ^ prev_q;
        end
    end

    // Register updates; a fresh edge is OR-ed in after the clear so set beats clear
    always_comb begin
        prev_d    = stable;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
            irqmask_d = writedata;
        end
        if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata;
        end
        edgecap_d = edgecap_d | edge_det;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    // Read mux evaluated every clock; chipselect is not needed for reads
    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:    readdata_d = stable;
            PIO_ADDR_RSVD:    readdata_d = '0;
            PIO_ADDR_IRQMASK: readdata_d = irqmask_q;
            PIO_ADDR_EDGECAP: readdata_d = edgecap_q;
            default:          readdata_d = '0;
        endcase
    end

    // All control and status flops, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture. Four instances share one bus and one
// input vector: rising, falling and any-edge without debounce, and rising
// with a 4-sample debouncer. Inputs change on the falling clock edge and
// outputs are checked there, halfway between active edges.
module tb_pio_in_capture;

    logic       clk;
    logic       reset_n;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] in_port;

    logic [7:0] rd_r, rd_f, rd_a, rd_d;
    logic       irq_r, irq_f, irq_a, irq_d;

    int total;
    int bad;
    logic seen;

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_d), .irq(irq_d));

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus/input vector, let one active edge pass, return at the next falling edge
    task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wn,
                                 input logic [7:0] wdata, input logic [7:0] inp);
        address    = addr;
        chipselect = cs;
        write_n    = wn;
        writedata  = wdata;
        in_port    = inp;
        @(negedge clk);
    endtask

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Last-resort guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-derived expectations
    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 8'h00;
        in_port    = 8'h00;

        // Reset state and register reads
        repeat (3) @(negedge clk);
        checkOutput("rst_readdata", {24'h0, rd_r}, 32'h0);
        checkOutput("rst_irq", 32'(irq_r), 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'(a), 1'b0, 1'b1, 8'h00, 8'h00);
            checkOutput($sformatf("rst_read_addr%0d", a), {24'h0, rd_r}, 32'h0);
        end
        checkOutput("rst_irq_after", 32'(irq_r), 32'h0);

        // Rising capture, irq masking, write-1-to-clear
        applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_data_T", {24'h0, rd_r}, 32'h00);
        applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_data_T1", {24'h0, rd_r}, 32'h00);
        applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_data_T2", {24'h0, rd_r}, 32'h05);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_edgecap", {24'h0, rd_r}, 32'h05);
        checkOutput("t2_irq_masked", 32'(irq_r), 32'h0);
        applyStimulus(2'd2, 1'b1, 1'b0, 8'h04, 8'h05);
        checkOutput("t2_irq_same_edge", 32'(irq_r), 32'h0);
        applyStimulus(2'd2, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_irq_set", 32'(irq_r), 32'h1);
        checkOutput("t2_irqmask_read", {24'h0, rd_r}, 32'h04);
        applyStimulus(2'd2, 1'b0, 1'b0, 8'hFF, 8'h05);
        applyStimulus(2'd2, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_cs_gates_write", {24'h0, rd_r}, 32'h04);
        applyStimulus(2'd1, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_reserved_read", {24'h0, rd_r}, 32'h00);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'h04, 8'h05);
        checkOutput("t2_irq_clear_edge", 32'(irq_r), 32'h1);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h05);
        checkOutput("t2_w1c", {24'h0, rd_r}, 32'h01);
        checkOutput("t2_irq_cleared", 32'(irq_r), 32'h0);

        // Falling versus any-edge on a pulse of bit 3
        repeat (8) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'hFF, 8'h00);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t3_fall_clean", {24'h0, rd_f}, 32'h00);
        checkOutput("t3_any_clean", {24'h0, rd_a}, 32'h00);
        repeat (5) applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h08);
        checkOutput("t3_fall_ignores_rise", {24'h0, rd_f}, 32'h00);
        checkOutput("t3_any_rise", {24'h0, rd_a}, 32'h08);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'h08, 8'h08);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t3_any_cleared", {24'h0, rd_a}, 32'h00);
        repeat (3) applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t3_fall_capture", {24'h0, rd_f}, 32'h08);
        checkOutput("t3_any_fall", {24'h0, rd_a}, 32'h08);

        // Debounce: 3 samples rejected, 4 samples accepted
        repeat (8) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'hFF, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h01);
            seen = seen | rd_d[0];
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
            seen = seen | rd_d[0];
        end
        checkOutput("t4_short_data", 32'(seen), 32'h0);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t4_short_cap", {24'h0, rd_d}, 32'h00);
        repeat (4) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h01);
        repeat (2) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t4_not_yet", {24'h0, rd_d}, 32'h00);
        applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t4_data", {24'h0, rd_d}, 32'h01);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t4_cap", {24'h0, rd_d}, 32'h01);

        // Set and write-1-clear on the same clock: set wins
        repeat (8) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'hFF, 8'h00);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h01);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h01);
        applyStimulus(2'd3, 1'b1, 1'b0, 8'h01, 8'h01);
        applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h01);
        checkOutput("t5_collision_rise", {24'h0, rd_r}, 32'h01);
        checkOutput("t5_collision_any", {24'h0, rd_a}, 32'h01);

        // Reset mid-debounce with irq high, then post-reset recapture
        repeat (8) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h01);
        applyStimulus(2'd2, 1'b1, 1'b0, 8'h01, 8'h01);
        applyStimulus(2'd2, 1'b0, 1'b1, 8'h00, 8'h01);
        checkOutput("t6_irq_pre", 32'(irq_d), 32'h1);
        repeat (4) applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("t6_irq_hold", 32'(irq_d), 32'h1);
        reset_n = 1'b0;
        applyStimulus(2'd0, 1'b0, 1'b1, 8'h00, 8'h01);
        checkOutput("t6_irq_reset", 32'(irq_d), 32'h0);
        checkOutput("t6_readdata_reset", {24'h0, rd_d}, 32'h00);
        reset_n = 1'b1;
        applyStimulus(2'd2, 1'b0, 1'b1, 8'h00, 8'h01);
        checkOutput("t6_irqmask_reset", {24'h0, rd_d}, 32'h00);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(2'd3, 1'b0, 1'b1, 8'h00, 8'h01);
            checkOutput($sformatf("t6_recap_deb_R%0d", k), {24'h0, rd_d}, (k >= 8) ? 32'h01 : 32'h00);
            checkOutput($sformatf("t6_recap_rise_R%0d", k), {24'h0, rd_r}, (k >= 4) ? 32'h01 : 32'h00);
            checkOutput($sformatf("t6_no_irq_R%0d", k), 32'(irq_r), 32'h0);
        end
        checkOutput("t6_fall_none", {24'h0, rd_f}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
